cpu_clk_ctrl: RTL

Run/step/halt controller for the CPU clock. It replaces the free-running divided clock with a sequenced one. From the board clock it derives a 50%-duty clk_cpu plus a one-cycle cpu_ce strobe, selectable between fast and slow rate. Speed and mode changes take effect only on period boundaries, so clk_cpu never glitches or truncates. Debug features: debounced single-step, CPU-requested halt, and a retired-cycle counter.

---
 rtl/cpu_clk_ctrl_if.sv | 22 ++
 rtl/cpu_clk_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Signal bundle between the CPU clock controller and its surroundings:
// raw operator/CPU controls in, sequenced CPU clock and debug status out.
interface cpu_clk_ctrl_if;
  logic        run_sw;
  logic        speed_sw;
  logic        step_btn;
  logic        halt_req;
  logic        clk_cpu;
  logic        cpu_ce;
  logic [31:0] cyc_cnt;
  logic [1:0]  state;

  modport master (
    output run_sw, speed_sw, step_btn, halt_req,
    input  clk_cpu, cpu_ce, cyc_cnt, state
  );

  modport slave (
    input  run_sw, speed_sw, step_btn, halt_req,
    output clk_cpu, cpu_ce, cyc_cnt, state
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer for the CPU clock: glitch-free 50% clk_cpu plus cpu_ce strobe,
// rate and mode changes applied only on period boundaries.
module cpu_clk_ctrl #(
  parameter int unsigned FAST_PERIOD = 4,
  parameter int unsigned SLOW_PERIOD = 16,
  parameter int unsigned DB_CNT      = 4,
  parameter int unsigned PW          = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  localparam logic [PW-1:0] FastP  = PW'(FAST_PERIOD);
  localparam logic [PW-1:0] SlowP  = PW'(SLOW_PERIOD);
  localparam int unsigned   DbW    = $clog2(DB_CNT + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CNT - 1);

  logic run_meta_q, run_sync_q;
  logic speed_meta_q, speed_sync_q;
  logic step_meta_q, step_sync_q;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           db_level_q, db_level_d;
  logic           db_prev_q;
  logic           step_pulse;

  state_e         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [PW-1:0]  cur_p_q, cur_p_d;
  logic           halt_pend_q, halt_pend_d;
  logic [31:0]    cyc_q;

  logic           period_end;
  logic [PW-1:0]  sel_p;
  logic           cpu_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      speed_meta_q <= 1'b0;
      speed_sync_q <= 1'b0;
      step_meta_q  <= 1'b0;
      step_sync_q  <= 1'b0;
      db_cnt_q     <= '0;
      db_level_q   <= 1'b0;
      db_prev_q    <= 1'b0;
    end else begin
      run_meta_q   <= bus.run_sw;
      run_sync_q   <= run_meta_q;
      speed_meta_q <= bus.speed_sw;
      speed_sync_q <= speed_meta_q;
      step_meta_q  <= bus.step_btn;
      step_sync_q  <= step_meta_q;
      db_cnt_q     <= db_cnt_d;
      db_level_q   <= db_level_d;
      db_prev_q    <= db_level_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any agreeing
  // sample (i.e. a bounce back) restarts the count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (step_sync_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_cnt_d   = '0;
      db_level_d = step_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign step_pulse = db_level_q & ~db_prev_q;

  assign period_end = (phase_q == cur_p_q - 1'b1);
  assign sel_p      = speed_sync_q ? SlowP : FastP;

  // A halt request seen at any point of a RUN period stops the clock at that period end.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cur_p_d     = cur_p_q;
    halt_pend_d = 1'b0;
    unique case (state_q)
      StHalt: begin
        phase_d = '0;
        cur_p_d = sel_p;
        if (run_sync_q && !bus.halt_req) begin
          state_d = StRun;
        end else if (step_pulse && !run_sync_q) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (period_end) begin
          phase_d = '0;
          cur_p_d = sel_p;
          if (!run_sync_q || bus.halt_req || halt_pend_q) begin
            state_d = StHalt;
          end
        end else begin
          phase_d     = phase_q + 1'b1;
          halt_pend_d = halt_pend_q | bus.halt_req;
        end
      end
      StStep: begin
        if (period_end) begin
          phase_d = '0;
          cur_p_d = sel_p;
          state_d = StHalt;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = StHalt;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHalt;
      phase_q     <= '0;
      cur_p_q     <= FastP;
      halt_pend_q <= 1'b0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cur_p_q     <= cur_p_d;
      halt_pend_q <= halt_pend_d;
      cyc_q       <= cyc_q + {31'b0, cpu_ce};
    end
  end

  assign cpu_ce      = (state_q != StHalt) && (phase_q == '0);
  assign bus.cpu_ce  = cpu_ce;
  assign bus.clk_cpu = (state_q != StHalt) && (phase_q < (cur_p_q >> 1));
  assign bus.cyc_cnt = cyc_q;
  assign bus.state   = state_q;

endmodule
